// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/EXEC/MEM/WB control sequencer for the 8-bit CPU
//
// Owns the program counter, steps each instruction through FETCH, EXEC, optional
// MEM and WB, and turns level decodes into single-cycle write strobes.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   run, step                  free-run level / single-instruction pulse
//   instr                      current instruction at pc
//   reg_write_in, flags_write_in, dm_write_in, is_mem_access   ControlUnit decodes
//   is_jump, is_jz, is_jnz, is_jl, is_jg                        jump decodes
//   zf, sf, of                 latched flags
//   pc                         program counter
//   ir_load, reg_write_en, flags_write_en, dm_write_en          one-cycle strobes
//   state, busy, halted        FSM state and status
//   retired                    completed-instruction counter
module cpu_sequencer #(
  parameter int             PC_W        = 8,
  parameter int             IW          = 16,
  parameter logic [4:0]     HALT_OPCODE = 5'b11111,
  parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
  parameter int             CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic [IW-1:0]    instr,
  input  logic             reg_write_in,
  input  logic             flags_write_in,
  input  logic             dm_write_in,
  input  logic             is_mem_access,
  input  logic             is_jump,
  input  logic             is_jz,
  input  logic             is_jnz,
  input  logic             is_jl,
  input  logic             is_jg,
  input  logic             zf,
  input  logic             sf,
  input  logic             of,
  output logic [PC_W-1:0]  pc,
  output logic             ir_load,
  output logic             reg_write_en,
  output logic             flags_write_en,
  output logic             dm_write_en,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            single_step_q, single_step_d;
  logic [PC_W-1:0] pc_q;
  logic [CNT_W-1:0] retired_q;
  logic            busy_q, halted_q;
  logic            taken;
  logic            is_halt;
  logic            ir_load_c, reg_we_c, flags_we_c, dm_we_c;

  // Only the opcode and jump-target fields are consumed here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[IW-6:PC_W];

  assign is_halt = (instr[IW-1:IW-5] == HALT_OPCODE);

  // Priority: unconditional jump first, then jz, jnz, jl, jg.
  always_comb begin
    taken = 1'b0;
    if (is_jump)     taken = 1'b1;
    else if (is_jz)  taken = zf;
    else if (is_jnz) taken = !zf;
    else if (is_jl)  taken = sf ^ of;
    else if (is_jg)  taken = !zf && !(sf ^ of);
  end

  always_comb begin
    state_d       = state_q;
    single_step_d = single_step_q;
    ir_load_c     = 1'b0;
    reg_we_c      = 1'b0;
    flags_we_c    = 1'b0;
    dm_we_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else if (step) begin
          state_d       = S_FETCH;
          single_step_d = 1'b1;
        end
      end
      S_FETCH: begin
        ir_load_c = 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else begin
          flags_we_c = flags_write_in;
          state_d    = is_mem_access ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        dm_we_c = dm_write_in;
        state_d = S_WB;
      end
      S_WB: begin
        reg_we_c = reg_write_in;
        if (run && !single_step_q) begin
          state_d = S_FETCH;
        end else begin
          state_d       = S_IDLE;
          single_step_d = 1'b0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are combinational, so a reset cycle must mask them directly.
  assign ir_load        = ir_load_c  && rst_n;
  assign reg_write_en   = reg_we_c   && rst_n;
  assign flags_write_en = flags_we_c && rst_n;
  assign dm_write_en    = dm_we_c    && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      single_step_q <= 1'b0;
      pc_q          <= RESET_PC;
      retired_q     <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      single_step_q <= single_step_d;
      busy_q        <= (state_d == S_FETCH) || (state_d == S_EXEC) ||
                       (state_d == S_MEM)   || (state_d == S_WB);
      halted_q      <= (state_d == S_HALT);
      if (state_q == S_WB) begin
        pc_q      <= taken ? instr[PC_W-1:0] : pc_q + PC_W'(1);
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - table-driven self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, step;
  logic [15:0] instr;
  logic        reg_write_in, flags_write_in, dm_write_in, is_mem_access;
  logic        is_jump, is_jz, is_jnz, is_jl, is_jg;
  logic        zf, sf, of;
  logic [7:0]  pc;
  logic        ir_load, reg_write_en, flags_write_en, dm_write_en;
  logic [2:0]  state;
  logic        busy, halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .instr(instr),
    .reg_write_in(reg_write_in), .flags_write_in(flags_write_in),
    .dm_write_in(dm_write_in), .is_mem_access(is_mem_access),
    .is_jump(is_jump), .is_jz(is_jz), .is_jnz(is_jnz), .is_jl(is_jl), .is_jg(is_jg),
    .zf(zf), .sf(sf), .of(of), .pc(pc), .ir_load(ir_load),
    .reg_write_en(reg_write_en), .flags_write_en(flags_write_en),
    .dm_write_en(dm_write_en), .state(state), .busy(busy), .halted(halted),
    .retired(retired)
  );

  // wr = {reg_write_in, flags_write_in, dm_write_in, is_mem_access}
  // jmp = {is_jump, is_jz, is_jnz, is_jl, is_jg}; flg = {zf, sf, of}
  // e_strb = {ir_load, flags_write_en, dm_write_en, reg_write_en}
  typedef struct {
    logic        run, step;
    logic [15:0] instr;
    logic [3:0]  wr;
    logic [4:0]  jmp;
    logic [2:0]  flg;
    logic [2:0]  e_state;
    logic [7:0]  e_pc;
    logic [3:0]  e_strb;
    logic [15:0] e_ret;
  } vec_t;

  localparam logic [15:0] ALU = 16'h0800, JT = 16'h0840, HLT = 16'hF800;
  localparam logic [3:0] W_ALU = 4'b1100, W_ST = 4'b0011, W_RW = 4'b1000, W_ALL = 4'b1111;
  localparam logic [4:0] J_JMP = 5'b10000, J_JZ = 5'b01000, J_JL = 5'b00010,
                         J_JG = 5'b00001, J_JMP_JNZ = 5'b10100;

  int checks = 0;
  int errors = 0;
  int row = 0;
  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic s, input logic [15:0] i,
                             input logic [3:0] w, input logic [4:0] j, input logic [2:0] f,
                             input logic [2:0] es, input logic [7:0] ep,
                             input logic [3:0] eb, input logic [15:0] er);
    vec_t t;
    t.run = r; t.step = s; t.instr = i; t.wr = w; t.jmp = j; t.flg = f;
    t.e_state = es; t.e_pc = ep; t.e_strb = eb; t.e_ret = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t t);
    run = t.run; step = t.step; instr = t.instr;
    {reg_write_in, flags_write_in, dm_write_in, is_mem_access} = t.wr;
    {is_jump, is_jz, is_jnz, is_jl, is_jg} = t.jmp;
    {zf, sf, of} = t.flg;
    @(negedge clk);
    chk("state", 32'(state), 32'(t.e_state));
    chk("pc", 32'(pc), 32'(t.e_pc));
    chk("strobes", 32'({ir_load, flags_write_en, dm_write_en, reg_write_en}), 32'(t.e_strb));
    chk("retired", 32'(retired), 32'(t.e_ret));
    chk("busy", 32'(busy), 32'(t.e_state >= 3'd1 && t.e_state <= 3'd4));
    chk("halted", 32'(halted), 32'(t.e_state == 3'd5));
    @(posedge clk); #1;
    row++;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; instr = '0;
    {reg_write_in, flags_write_in, dm_write_in, is_mem_access} = '0;
    {is_jump, is_jz, is_jnz, is_jl, is_jg} = '0;
    {zf, sf, of} = '0;

    // single step of an ALU op, with extra step pulses mid-instruction
    tbl.push_back(v(0,1,ALU,W_ALU,0,0,     0,8'h00,4'b0000,0));
    tbl.push_back(v(0,1,ALU,W_ALU,0,0,     1,8'h00,4'b1000,0));
    tbl.push_back(v(0,0,ALU,W_ALU,0,0,     2,8'h00,4'b0100,0));
    tbl.push_back(v(0,1,ALU,W_ALU,0,0,     4,8'h00,4'b0001,0));
    tbl.push_back(v(0,0,ALU,W_ALU,0,0,     0,8'h01,4'b0000,1));
    tbl.push_back(v(0,0,ALU,W_ALU,0,0,     0,8'h01,4'b0000,1));
    // stores under run, run dropped during the second store
    tbl.push_back(v(1,0,ALU,W_ST,0,0,      0,8'h01,4'b0000,1));
    tbl.push_back(v(1,0,ALU,W_ST,0,0,      1,8'h01,4'b1000,1));
    tbl.push_back(v(1,0,ALU,W_ST,0,0,      2,8'h01,4'b0000,1));
    tbl.push_back(v(1,0,ALU,W_ST,0,0,      3,8'h01,4'b0010,1));
    tbl.push_back(v(1,0,ALU,W_ST,0,0,      4,8'h01,4'b0000,1));
    tbl.push_back(v(1,0,ALU,W_ST,0,0,      1,8'h02,4'b1000,2));
    tbl.push_back(v(0,0,ALU,W_ST,0,0,      2,8'h02,4'b0000,2));
    tbl.push_back(v(0,0,ALU,W_ST,0,0,      3,8'h02,4'b0010,2));
    tbl.push_back(v(0,0,ALU,W_ST,0,0,      4,8'h02,4'b0000,2));
    tbl.push_back(v(0,0,ALU,W_ST,0,0,      0,8'h03,4'b0000,3));
    // jumps to 8'h40
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b100, 0,8'h03,4'b0000,3));
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b100, 1,8'h03,4'b1000,3));
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b100, 2,8'h03,4'b0000,3));
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b100, 4,8'h03,4'b0001,3));
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b000, 1,8'h40,4'b1000,4));
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b000, 2,8'h40,4'b0000,4));
    tbl.push_back(v(1,0,JT,W_RW,J_JZ,3'b000, 4,8'h40,4'b0001,4));
    tbl.push_back(v(1,0,JT,W_RW,J_JL,3'b010, 1,8'h41,4'b1000,5));
    tbl.push_back(v(1,0,JT,W_RW,J_JL,3'b010, 2,8'h41,4'b0000,5));
    tbl.push_back(v(1,0,JT,W_RW,J_JL,3'b010, 4,8'h41,4'b0001,5));
    tbl.push_back(v(1,0,JT,W_RW,J_JG,3'b011, 1,8'h40,4'b1000,6));
    tbl.push_back(v(1,0,JT,W_RW,J_JG,3'b011, 2,8'h40,4'b0000,6));
    tbl.push_back(v(1,0,JT,W_RW,J_JG,3'b011, 4,8'h40,4'b0001,6));
    tbl.push_back(v(1,0,JT,W_RW,J_JMP_JNZ,3'b100, 1,8'h40,4'b1000,7));
    tbl.push_back(v(1,0,JT,W_RW,J_JMP_JNZ,3'b100, 2,8'h40,4'b0000,7));
    tbl.push_back(v(1,0,JT,W_RW,J_JMP_JNZ,3'b100, 4,8'h40,4'b0001,7));
    tbl.push_back(v(1,0,JT,W_RW,J_JG,3'b010, 1,8'h40,4'b1000,8));
    tbl.push_back(v(0,0,JT,W_RW,J_JG,3'b010, 2,8'h40,4'b0000,8));
    tbl.push_back(v(0,0,JT,W_RW,J_JG,3'b010, 4,8'h40,4'b0001,8));
    tbl.push_back(v(0,0,JT,W_RW,J_JG,3'b010, 0,8'h41,4'b0000,9));

    // reset for two cycles, then idle with every decode asserted
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(v(0,0,ALU,W_ALL,J_JMP,3'b111, 0,8'h00,4'b0000,0));

    foreach (tbl[i]) cyc(tbl[i]);

    // step a jump to 8'hFF, then step an ALU op to wrap pc to 8'h00
    cyc(v(0,1,16'h08FF,W_RW,J_JMP,0, 0,8'h41,4'b0000,9));
    cyc(v(0,0,16'h08FF,W_RW,J_JMP,0, 1,8'h41,4'b1000,9));
    cyc(v(0,0,16'h08FF,W_RW,J_JMP,0, 2,8'h41,4'b0000,9));
    cyc(v(0,0,16'h08FF,W_RW,J_JMP,0, 4,8'h41,4'b0001,9));
    cyc(v(0,1,ALU,W_ALU,0,0,         0,8'hFF,4'b0000,10));
    cyc(v(0,0,ALU,W_ALU,0,0,         1,8'hFF,4'b1000,10));
    cyc(v(0,0,ALU,W_ALU,0,0,         2,8'hFF,4'b0100,10));
    cyc(v(0,0,ALU,W_ALU,0,0,         4,8'hFF,4'b0001,10));
    cyc(v(0,0,ALU,W_ALU,0,0,         0,8'h00,4'b0000,11));

    // halt opcode: flags strobe suppressed in EXEC, then frozen in HALT
    cyc(v(1,0,HLT,W_ALL,J_JMP,0, 0,8'h00,4'b0000,11));
    cyc(v(1,0,HLT,W_ALL,J_JMP,0, 1,8'h00,4'b1000,11));
    cyc(v(1,0,HLT,W_ALL,J_JMP,0, 2,8'h00,4'b0000,11));
    for (int i = 0; i < 20; i++)
      cyc(v(i[0],i[1],HLT,W_ALL,J_JMP,0, 5,8'h00,4'b0000,11));

    // reset out of HALT
    rst_n = 1'b0;
    cyc(v(0,0,HLT,W_ALL,0,0, 5,8'h00,4'b0000,11));
    rst_n = 1'b1;

    // one store completes, reset lands in the MEM cycle of the next
    cyc(v(1,0,ALU,W_ST,0,0, 0,8'h00,4'b0000,0));
    cyc(v(1,0,ALU,W_ST,0,0, 1,8'h00,4'b1000,0));
    cyc(v(1,0,ALU,W_ST,0,0, 2,8'h00,4'b0000,0));
    cyc(v(1,0,ALU,W_ST,0,0, 3,8'h00,4'b0010,0));
    cyc(v(1,0,ALU,W_ST,0,0, 4,8'h00,4'b0000,0));
    cyc(v(1,0,ALU,W_ST,0,0, 1,8'h01,4'b1000,1));
    cyc(v(1,0,ALU,W_ST,0,0, 2,8'h01,4'b0000,1));
    rst_n = 1'b0;
    cyc(v(1,0,ALU,W_ST,0,0, 3,8'h01,4'b0000,1));
    rst_n = 1'b1;
    cyc(v(0,0,ALU,W_ST,0,0, 0,8'h00,4'b0000,0));
    cyc(v(0,0,ALU,W_ST,0,0, 0,8'h00,4'b0000,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
